// File: rtl/usb_audio_i2s_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_audio_i2s_bridge: PCM strobe/sample port to I2S master (DAC + ADC).  |
// | Optional I2S_LEFT_JUSTIFIED_EN selects left-justified serial format.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module usb_audio_i2s_bridge #(
  parameter int FRAME_CYCLES   = 1250,
  parameter int RX_UPDATE_SLOT = 56
) (
  input  logic        rstn,
  input  logic        clk,
  input  logic        audio_en,
  input  logic [15:0] audio_lo,
  input  logic [15:0] audio_ro,
  output logic [15:0] audio_li,
  output logic [15:0] audio_ri,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdout,
  input  logic        i2s_sdin
);

  localparam logic [10:0] c_ACC_STEP = 11'd128;
  localparam logic [10:0] c_FRAME    = 11'(FRAME_CYCLES);
  localparam logic [6:0]  c_UPDATE_H = 7'(2 * RX_UPDATE_SLOT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [10:0] r_acc;
  logic [6:0]  r_h;
  logic [31:0] r_tx;
  logic [15:0] r_rx_l;
  logic [15:0] r_rx_r;
  logic [1:0]  r_sync;
  logic        r_sdout;

  logic [10:0] w_acc_sum;
  logic        w_tick;
  logic [6:0]  w_h_next;
  logic [4:0]  w_s_next;
  logic [15:0] w_word_next;
  logic        w_s_in_range;
  logic        w_tx_bit;

  // Everything below is evaluated for the half-bit position the next tick enters.
  always_comb begin
    w_acc_sum   = r_acc + c_ACC_STEP;
    w_tick      = (r_state == ST_RUN) && (w_acc_sum >= c_FRAME);
    w_h_next    = r_h + 7'd1;
    w_s_next    = w_h_next[5:1];
    w_word_next = w_h_next[6] ? r_tx[31:16] : r_tx[15:0];
`ifdef I2S_LEFT_JUSTIFIED_EN
    w_s_in_range = ~w_s_next[4];
    w_tx_bit     = w_word_next[4'd15 - w_s_next[3:0]];
`else
    w_s_in_range = (w_s_next >= 5'd1) && (w_s_next <= 5'd16);
    w_tx_bit     = w_word_next[4'(5'd16 - w_s_next)];
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_h      <= '0;
      r_tx     <= '0;
      r_rx_l   <= '0;
      r_rx_r   <= '0;
      r_sync   <= '0;
      r_sdout  <= 1'b0;
      audio_li <= '0;
      audio_ri <= '0;
    end else begin
      r_sync <= {r_sync[0], i2s_sdin};
      if (audio_en) begin
        r_state <= ST_RUN;
        r_acc   <= '0;
        r_h     <= '0;
        r_tx    <= {audio_ro, audio_lo};
`ifdef I2S_LEFT_JUSTIFIED_EN
        r_sdout <= audio_lo[15];
`else
        r_sdout <= 1'b0;
`endif
      end else if (r_state == ST_RUN) begin
        if (w_tick) begin
          r_acc <= w_acc_sum - c_FRAME;
          r_h   <= w_h_next;
          if (!w_h_next[0]) begin
            r_sdout <= w_s_in_range & w_tx_bit;
            if (w_h_next == c_UPDATE_H) begin
              audio_li <= r_rx_l;
              audio_ri <= r_rx_r;
            end
          end else if (w_s_in_range) begin
            if (w_h_next[6]) r_rx_r <= {r_rx_r[14:0], r_sync[1]};
            else             r_rx_l <= {r_rx_l[14:0], r_sync[1]};
          end
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

  assign i2s_bclk  = r_h[0];
  assign i2s_lrck  = r_h[6];
  assign i2s_sdout = r_sdout;

endmodule
`default_nettype wire

// File: tb/tb_usb_audio_i2s_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_usb_audio_i2s_bridge: randomized bench with closed-form frame model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_usb_audio_i2s_bridge;

  localparam int c_FRAME = 1250;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        audio_en = 1'b0;
  logic [15:0] audio_lo = '0;
  logic [15:0] audio_ro = '0;
  logic [15:0] audio_li;
  logic [15:0] audio_ri;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdout;
  logic        i2s_sdin;
  logic        loop_en = 1'b0;
  logic        noise = 1'b0;

  assign i2s_sdin = loop_en ? i2s_sdout : noise;

  usb_audio_i2s_bridge dut (
    .rstn      (rstn),
    .clk       (clk),
    .audio_en  (audio_en),
    .audio_lo  (audio_lo),
    .audio_ro  (audio_ro),
    .audio_li  (audio_li),
    .audio_ri  (audio_ri),
    .i2s_bclk  (i2s_bclk),
    .i2s_lrck  (i2s_lrck),
    .i2s_sdout (i2s_sdout),
    .i2s_sdin  (i2s_sdin)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: after n clocks since audio_en, h = floor(128*n/1250) mod 128.
  logic        m_run;
  int          m_n;
  int          m_h;
  int          m_hprev;
  logic [15:0] m_lo, m_ro, m_li, m_ri;
  int          rise_cnt;
  int          run_len;
  logic        run_valid;
  logic        prev_bclk;
  logic [63:0] sd_bits, lr_bits;

  function automatic logic exp_sd(input int h, input logic [15:0] lo, input logic [15:0] ro);
    int b, s;
    logic [15:0] w;
    b = h / 2;
    s = b % 32;
    w = (b < 32) ? lo : ro;
`ifdef I2S_LEFT_JUSTIFIED_EN
    return (s <= 15) ? w[15 - s] : 1'b0;
`else
    return (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_n = 0; m_h = 0; m_hprev = 0;
    m_lo = '0; m_ro = '0; m_li = '0; m_ri = '0;
    rise_cnt = 0; run_len = 0; run_valid = 0; prev_bclk = 0;
    sd_bits = '0; lr_bits = '0;
  endtask

  task automatic cyc(input logic en, input logic [15:0] lo, input logic [15:0] ro);
    logic [34:0] exp_v;
    audio_en = en; audio_lo = lo; audio_ro = ro;
    @(posedge clk);
    #1;
    audio_en = 1'b0;
    if (!rstn) begin
      model_reset();
    end else if (en) begin
      m_run = 1; m_n = 0; m_lo = lo; m_ro = ro;
      rise_cnt = 0; run_valid = 0; run_len = 0;
    end else if (m_run) begin
      m_n++;
    end
    m_h = m_run ? ((128 * m_n) / c_FRAME) % 128 : 0;
    if (m_run && m_h == 112 && m_hprev != 112) begin
      m_li = m_lo;
      m_ri = m_ro;
    end
    m_hprev = m_h;
    exp_v = {m_h[0], m_h[6], exp_sd(m_h, m_lo, m_ro), m_li, m_ri};
    check("outputs", {29'd0, i2s_bclk, i2s_lrck, i2s_sdout, audio_li, audio_ri}, {29'd0, exp_v});
    if (m_run) begin
      if (i2s_bclk != prev_bclk) begin
        if (run_valid) check("half_period", (run_len >= 9 && run_len <= 10), 1);
        run_valid = 1;
        run_len = 1;
        if (i2s_bclk) begin
          if (rise_cnt < 64) begin
            sd_bits[rise_cnt] = i2s_sdout;
            lr_bits[rise_cnt] = i2s_lrck;
          end
          rise_cnt++;
        end
      end else begin
        run_len++;
      end
    end
    prev_bclk = i2s_bclk;
  endtask

  // Decodes the serial stream captured on BCLK rising edges of one full frame.
  task automatic frame_check(input logic [15:0] lo, input logic [15:0] ro);
    logic [15:0] dl, dr;
    logic z;
    check("rises_per_frame", rise_cnt, 64);
    check("lrck_slots", lr_bits, {32'hFFFF_FFFF, 32'h0});
    for (int i = 0; i < 16; i++) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
      dl[15 - i] = sd_bits[i];
      dr[15 - i] = sd_bits[32 + i];
`else
      dl[15 - i] = sd_bits[1 + i];
      dr[15 - i] = sd_bits[33 + i];
`endif
    end
    check("decode_left", dl, lo);
    check("decode_right", dr, ro);
`ifndef I2S_LEFT_JUSTIFIED_EN
    z = sd_bits[0] | sd_bits[32];
    for (int i = 17; i < 32; i++) z = z | sd_bits[i];
    check("zero_slots", z, 0);
`endif
  endtask

  task automatic run_frame(input logic [15:0] lo, input logic [15:0] ro);
    cyc(1'b1, lo, ro);
    for (int i = 1; i < c_FRAME; i++) cyc(1'b0, lo, ro);
    frame_check(lo, ro);
  endtask

  initial begin
    logic [15:0] lo, ro;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 16'h0);
    rstn = 1'b1;

    // No strobe: bus stays quiet regardless of ADC line activity.
    for (int i = 0; i < 5000; i++) begin
      noise = 1'($urandom_range(0, 1));
      cyc(1'b0, 16'($urandom), 16'($urandom));
    end
    check("idle_li", audio_li, 16'h0);

    loop_en = 1'b1;
    run_frame(16'hA5C3, 16'h3C5A);
    run_frame(16'h8001, 16'h7FFE);
    check("loop_li", audio_li, 16'h8001);
    check("loop_ri", audio_ri, 16'h7FFE);
    run_frame(16'h8000, 16'h0001);
    for (int f = 0; f < 3; f++) run_frame(16'($urandom), 16'($urandom));

    // One suppressed strobe: the frame wraps and repeats the latched words.
    lo = 16'($urandom); ro = 16'($urandom);
    cyc(1'b1, lo, ro);
    for (int i = 1; i < 2 * c_FRAME; i++) cyc(1'b0, 16'($urandom), 16'($urandom));
    run_frame(16'($urandom), 16'($urandom));

    // Early strobe at cycle 600 of a frame.
    lo = 16'($urandom); ro = 16'($urandom);
    cyc(1'b1, lo, ro);
    for (int i = 1; i < 600; i++) cyc(1'b0, lo, ro);
    run_frame(16'($urandom), 16'($urandom));

    // Reset asserted once slot 40 is reached.
    lo = 16'($urandom); ro = 16'($urandom);
    cyc(1'b1, lo, ro);
    for (int i = 0; i < c_FRAME && m_h < 80; i++) cyc(1'b0, lo, ro);
    rstn = 1'b0;
    #1;
    check("rst_async", {i2s_bclk, i2s_lrck, i2s_sdout, audio_li, audio_ri}, 35'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, lo, ro);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b0, lo, ro);
    run_frame(16'($urandom), 16'($urandom));
    run_frame(16'($urandom), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
